// File: rtl/pwr_spec_acc_ctrl.sv
// ----------------------------------------------------------------------------
// pwr_spec_acc_ctrl
//
// Purpose:
//   Squares incoming complex FFT samples (re^2 + im^2) in a 3-stage pipeline.
//   A small FSM sequences a multi-pulse accumulation run for a downstream
//   accumulator buffer. Buffer_En tells the downstream buffer when to
//   accumulate (high) and when to drain (low).
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   fft_re       in   [24:0] signed FFT real part
//   fft_im       in   [24:0] signed FFT imaginary part
//   fft_valid    in   fft_re/fft_im valid this cycle
//   pulse_start  in   one-cycle strobe, laser pulse trigger
//   acc_start    in   one-cycle strobe, begin an accumulation run
//   pulse_num    in   [15:0] pulses per run, sampled on accepted acc_start
//   data_out     out  [49:0] unsigned power value re^2 + im^2
//   valid_out    out  data_out valid
//   is_first_pls out  current pulse is the first of the run
//   Buffer_En    out  high = downstream accumulates, low = downstream drains
//   acc_done     out  one-cycle strobe at end of run
//   pls_err      out  sticky: pulse_start arrived mid-pulse
// ----------------------------------------------------------------------------
module pwr_spec_acc_ctrl #(
    parameter int SAMPLES_PER_PLS = 8192,
    parameter int GUARD_CYC       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [24:0] fft_re,
    input  logic signed [24:0] fft_im,
    input  logic               fft_valid,
    input  logic               pulse_start,
    input  logic               acc_start,
    input  logic [15:0]        pulse_num,
    output logic [49:0]        data_out,
    output logic               valid_out,
    output logic               is_first_pls,
    output logic               Buffer_En,
    output logic               acc_done,
    output logic               pls_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PLS = 2'd1,
        COLLECT  = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [13:0] SAMPLE_LAST = 14'(SAMPLES_PER_PLS - 1);
    localparam logic [31:0] GUARD_LEN   = 32'(GUARD_CYC);

    // Control state
    state_t       state_q,      state_d;
    logic [15:0]  pulse_num_q,  pulse_num_d;
    logic [15:0]  pulse_cnt_q,  pulse_cnt_d;
    logic [13:0]  sample_cnt_q, sample_cnt_d;
    logic [15:0]  guard_cnt_q,  guard_cnt_d;
    logic         is_first_q,   is_first_d;
    logic         buf_en_q,     buf_en_d;
    logic         acc_done_q,   acc_done_d;
    logic         pls_err_q,    pls_err_d;

    // Power pipeline
    logic signed [24:0] re_q,       re_d;
    logic signed [24:0] im_q,       im_d;
    logic               s1_valid_q, s1_valid_d;
    logic        [49:0] sq_re_q,    sq_re_d;
    logic        [49:0] sq_im_q,    sq_im_d;
    logic               s2_valid_q, s2_valid_d;
    logic        [49:0] data_out_q, data_out_d;
    logic               valid_out_q, valid_out_d;

    logic signed [49:0] sq_re_full;
    logic signed [49:0] sq_im_full;

    logic        sample_accept;
    logic        last_sample;
    logic        final_pulse;
    logic [15:0] pulse_cnt_inc;
    logic        pipe_busy;
    logic        guard_done;

    // Only samples arriving while collecting enter the pipeline.
    assign sample_accept = (state_q == COLLECT) && fft_valid;
    assign last_sample   = sample_accept && (sample_cnt_q == SAMPLE_LAST);
    assign pulse_cnt_inc = pulse_cnt_q + 16'd1;
    assign final_pulse   = (pulse_cnt_inc == pulse_num_q);

    // The guard window only starts counting once the last sample has left
    // the pipeline, so Buffer_En drops GUARD_CYC+1 cycles after it.
    assign pipe_busy  = s1_valid_q | s2_valid_q | valid_out_q;
    assign guard_done = !pipe_busy && ((32'(guard_cnt_q) + 32'd1) >= GUARD_LEN);

    always_comb begin
        state_d      = state_q;
        pulse_num_d  = pulse_num_q;
        pulse_cnt_d  = pulse_cnt_q;
        sample_cnt_d = sample_cnt_q;
        guard_cnt_d  = guard_cnt_q;
        is_first_d   = is_first_q;
        buf_en_d     = buf_en_q;
        acc_done_d   = 1'b0;
        pls_err_d    = pls_err_q;

        case (state_q)
            IDLE: begin
                if (acc_start) begin
                    pulse_num_d  = (pulse_num == 16'd0) ? 16'd1 : pulse_num;
                    pulse_cnt_d  = 16'd0;
                    sample_cnt_d = 14'd0;
                    guard_cnt_d  = 16'd0;
                    is_first_d   = 1'b0;
                    buf_en_d     = 1'b1;
                    pls_err_d    = 1'b0;
                    state_d      = WAIT_PLS;
                end
            end

            WAIT_PLS: begin
                if (pulse_start) begin
                    sample_cnt_d = 14'd0;
                    is_first_d   = (pulse_cnt_q == 16'd0);
                    state_d      = COLLECT;
                end
            end

            COLLECT: begin
                if (sample_accept) begin
                    sample_cnt_d = sample_cnt_q + 14'd1;
                end
                if (last_sample) begin
                    sample_cnt_d = 14'd0;
                    pulse_cnt_d  = pulse_cnt_inc;
                    if (final_pulse) begin
                        guard_cnt_d = 16'd0;
                        state_d     = FLUSH;
                    end else if (pulse_start) begin
                        // Trigger coincident with the closing sample starts
                        // the next pulse immediately; it is never the first.
                        is_first_d = 1'b0;
                        state_d    = COLLECT;
                    end else begin
                        state_d = WAIT_PLS;
                    end
                end
                // Any other trigger during collection is a timing fault.
                if (pulse_start && !(last_sample && !final_pulse)) begin
                    pls_err_d = 1'b1;
                end
            end

            FLUSH: begin
                guard_cnt_d = pipe_busy ? 16'd0 : (guard_cnt_q + 16'd1);
                if (guard_done) begin
                    buf_en_d   = 1'b0;
                    acc_done_d = 1'b1;
                    is_first_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage 1 registers the raw inputs, stage 2 squares, stage 3 sums.
    // The full 50-bit signed product keeps (-2^24)^2 = 2^48 exact.
    always_comb begin
        re_d        = fft_re;
        im_d        = fft_im;
        s1_valid_d  = sample_accept;
        sq_re_full  = re_q * re_q;
        sq_im_full  = im_q * im_q;
        sq_re_d     = $unsigned(sq_re_full);
        sq_im_d     = $unsigned(sq_im_full);
        s2_valid_d  = s1_valid_q;
        data_out_d  = s2_valid_q ? (sq_re_q + sq_im_q) : data_out_q;
        valid_out_d = s2_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pulse_num_q  <= 16'd0;
            pulse_cnt_q  <= 16'd0;
            sample_cnt_q <= 14'd0;
            guard_cnt_q  <= 16'd0;
            is_first_q   <= 1'b0;
            buf_en_q     <= 1'b0;
            acc_done_q   <= 1'b0;
            pls_err_q    <= 1'b0;
            re_q         <= 25'sd0;
            im_q         <= 25'sd0;
            s1_valid_q   <= 1'b0;
            sq_re_q      <= 50'd0;
            sq_im_q      <= 50'd0;
            s2_valid_q   <= 1'b0;
            data_out_q   <= 50'd0;
            valid_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_num_q  <= pulse_num_d;
            pulse_cnt_q  <= pulse_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            guard_cnt_q  <= guard_cnt_d;
            is_first_q   <= is_first_d;
            buf_en_q     <= buf_en_d;
            acc_done_q   <= acc_done_d;
            pls_err_q    <= pls_err_d;
            re_q         <= re_d;
            im_q         <= im_d;
            s1_valid_q   <= s1_valid_d;
            sq_re_q      <= sq_re_d;
            sq_im_q      <= sq_im_d;
            s2_valid_q   <= s2_valid_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign is_first_pls = is_first_q;
    assign Buffer_En    = buf_en_q;
    assign acc_done     = acc_done_q;
    assign pls_err      = pls_err_q;

endmodule

// File: tb/tb_pwr_spec_acc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pwr_spec_acc_ctrl
//
// Self-checking bench for pwr_spec_acc_ctrl. Expected power values are
// pushed to a scoreboard queue when a sample that should be accepted is
// driven, and popped by a monitor whenever valid_out is seen.
// ----------------------------------------------------------------------------
module tb_pwr_spec_acc_ctrl;

    localparam int SPP   = 1024;
    localparam int GUARD = 4;

    logic               clk;
    logic               rst;
    logic signed [24:0] fft_re;
    logic signed [24:0] fft_im;
    logic               fft_valid;
    logic               pulse_start;
    logic               acc_start;
    logic [15:0]        pulse_num;
    logic [49:0]        data_out;
    logic               valid_out;
    logic               is_first_pls;
    logic               Buffer_En;
    logic               acc_done;
    logic               pls_err;

    typedef struct {
        logic [49:0] data;
        int          cyc;
    } sbEntry_t;

    sbEntry_t sb[$];
    sbEntry_t monEntry;

    int tests     = 0;
    int failures  = 0;
    int cyc       = 0;
    int voCount   = 0;
    int lastVoCyc = 0;

    pwr_spec_acc_ctrl #(
        .SAMPLES_PER_PLS(SPP),
        .GUARD_CYC      (GUARD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fft_re      (fft_re),
        .fft_im      (fft_im),
        .fft_valid   (fft_valid),
        .pulse_start (pulse_start),
        .acc_start   (acc_start),
        .pulse_num   (pulse_num),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .is_first_pls(is_first_pls),
        .Buffer_En   (Buffer_En),
        .acc_done    (acc_done),
        .pls_err     (pls_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests = tests + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference power model in 64-bit signed arithmetic.
    function automatic logic [49:0] powerOf(input logic signed [24:0] re, input logic signed [24:0] im);
        longint r;
        longint i;
        r = re;
        i = im;
        return 50'(r * r + i * i);
    endfunction

    // First two samples of each pulse hit the arithmetic corners.
    function automatic logic signed [24:0] pickVal(input int s, input bit second);
        logic signed [24:0] v;
        if (s == 0)
            v = 25'sh1000000;
        else if (s == 1)
            v = second ? 25'sh1000000 : 25'sh0FFFFFF;
        else
            v = 25'($urandom);
        return v;
    endfunction

    // Drive one cycle of inputs; queue the expected power if it should be accepted.
    task automatic applyStimulus(input logic signed [24:0] re, input logic signed [24:0] im,
                                 input logic v, input logic ps, input logic as,
                                 input logic [15:0] pn, input logic expAcc);
        sbEntry_t e;
        fft_re      = re;
        fft_im      = im;
        fft_valid   = v;
        pulse_start = ps;
        acc_start   = as;
        pulse_num   = pn;
        if (v && expAcc) begin
            e.data = powerOf(re, im);
            e.cyc  = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(25'sd0, 25'sd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic startRun(input logic [15:0] pn);
        applyStimulus(25'sd0, 25'sd0, 1'b0, 1'b0, 1'b1, pn, 1'b0);
    endtask

    task automatic doPulse(input logic expFirst, input logic skipStart, input int trigAt, input logic trigLast);
        logic signed [24:0] re;
        logic signed [24:0] im;
        logic ps;
        if (!skipStart)
            applyStimulus(25'sd0, 25'sd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        checkOutput("is_first_start", 64'(is_first_pls), 64'(expFirst));
        checkOutput("buf_en_collect", 64'(Buffer_En), 64'd1);
        for (int s = 0; s < SPP; s++) begin
            if (s > 0 && $urandom_range(15) == 0)
                idle();
            re = pickVal(s, 1'b0);
            im = pickVal(s, 1'b1);
            ps = (s == trigAt) || (trigLast && (s == SPP - 1));
            applyStimulus(re, im, 1'b1, ps, 1'b0, 16'd0, 1'b1);
            if (s == SPP / 2)
                checkOutput("is_first_hold", 64'(is_first_pls), 64'(expFirst));
        end
    endtask

    // Bounded wait for acc_done, then check the run closing behaviour.
    task automatic waitDone(input int voBase, input int expVo);
        bit lowEarly;
        lowEarly = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (acc_done)
                break;
            if (!Buffer_En)
                lowEarly = 1'b1;
            idle();
        end
        checkOutput("acc_done_seen", 64'(acc_done), 64'd1);
        checkOutput("buf_en_fall", 64'(Buffer_En), 64'd0);
        checkOutput("guard_gap", 64'(cyc - lastVoCyc), 64'(GUARD + 1));
        checkOutput("buf_en_early_low", 64'(lowEarly), 64'd0);
        checkOutput("vo_count", 64'(voCount - voBase), 64'(expVo));
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        idle();
        checkOutput("acc_done_pulse", 64'(acc_done), 64'd0);
        checkOutput("is_first_idle", 64'(is_first_pls), 64'd0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid_out) begin
            voCount   = voCount + 1;
            lastVoCyc = cyc;
            if (sb.size() == 0) begin
                checkOutput("vo_unexpected", 64'(valid_out), 64'd0);
            end else begin
                monEntry = sb.pop_front();
                checkOutput("data_out", 64'(data_out), 64'(monEntry.data));
                checkOutput("latency", 64'(cyc - monEntry.cyc), 64'd3);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int voBase;
        int voAtRst;

        rst         = 1'b1;
        fft_re      = 25'sd0;
        fft_im      = 25'sd0;
        fft_valid   = 1'b0;
        pulse_start = 1'b0;
        acc_start   = 1'b0;
        pulse_num   = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data_out", 64'(data_out), 64'd0);
        checkOutput("rst_valid_out", 64'(valid_out), 64'd0);
        checkOutput("rst_is_first", 64'(is_first_pls), 64'd0);
        checkOutput("rst_buf_en", 64'(Buffer_En), 64'd0);
        checkOutput("rst_acc_done", 64'(acc_done), 64'd0);
        checkOutput("rst_pls_err", 64'(pls_err), 64'd0);
        rst = 1'b0;

        // Samples and triggers in IDLE must be ignored.
        applyStimulus(25'sd77, 25'sd5, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        applyStimulus(25'sd9, -25'sd3, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        repeat (4) idle();
        checkOutput("idle_buf_en", 64'(Buffer_En), 64'd0);

        // Run of three pulses, with an ignored acc_start between pulses.
        voBase = voCount;
        startRun(16'd3);
        checkOutput("run_buf_en", 64'(Buffer_En), 64'd1);
        applyStimulus(25'sd123, 25'sd456, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        idle();
        doPulse(1'b1, 1'b0, -1, 1'b0);
        applyStimulus(25'sd5, 25'sd5, 1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
        checkOutput("is_first_wait", 64'(is_first_pls), 64'd1);
        doPulse(1'b0, 1'b0, -1, 1'b0);
        doPulse(1'b0, 1'b0, -1, 1'b0);
        waitDone(voBase, 3 * SPP);
        checkOutput("run3_pls_err", 64'(pls_err), 64'd0);

        // pulse_num = 0 behaves as a single pulse.
        voBase = voCount;
        startRun(16'd0);
        doPulse(1'b1, 1'b0, -1, 1'b0);
        waitDone(voBase, SPP);

        // Mid-pulse trigger is ignored and latches pls_err.
        voBase = voCount;
        startRun(16'd1);
        doPulse(1'b1, 1'b0, 100, 1'b0);
        checkOutput("mid_pls_err", 64'(pls_err), 64'd1);
        waitDone(voBase, SPP);
        checkOutput("mid_pls_err_sticky", 64'(pls_err), 64'd1);

        // Coincident trigger on the closing sample of pulse 0 of 2.
        voBase = voCount;
        startRun(16'd2);
        checkOutput("acc_start_clr_err", 64'(pls_err), 64'd0);
        doPulse(1'b1, 1'b0, -1, 1'b1);
        doPulse(1'b0, 1'b1, -1, 1'b0);
        checkOutput("coinc_pls_err", 64'(pls_err), 64'd0);
        waitDone(voBase, 2 * SPP);

        // Reset in the middle of a streaming pulse.
        startRun(16'd2);
        applyStimulus(25'sd0, 25'sd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
        for (int s = 0; s < 500; s++)
            applyStimulus(pickVal(s, 1'b0), pickVal(s, 1'b1), 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        rst = 1'b1;
        applyStimulus(25'sd1000, 25'sd1000, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        rst = 1'b0;
        sb.delete();
        voAtRst = voCount;
        checkOutput("mrst_data_out", 64'(data_out), 64'd0);
        checkOutput("mrst_valid_out", 64'(valid_out), 64'd0);
        checkOutput("mrst_is_first", 64'(is_first_pls), 64'd0);
        checkOutput("mrst_buf_en", 64'(Buffer_En), 64'd0);
        checkOutput("mrst_acc_done", 64'(acc_done), 64'd0);
        for (int s = 0; s < 20; s++)
            applyStimulus(25'($urandom), 25'($urandom), 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        idle();
        checkOutput("mrst_no_vo", 64'(voCount - voAtRst), 64'd0);

        // A fresh run after the abort works normally.
        voBase = voCount;
        startRun(16'd1);
        doPulse(1'b1, 1'b0, -1, 1'b0);
        waitDone(voBase, SPP);

        repeat (3) idle();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
